adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operation, so the operand width is 4*NIBBLES (16 bits at default).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port REQ, input, 2 bits: per-requester operation request, level-sensitive.
REQ-005 SHALL have ports OPA_0 and OPB_0, inputs, 4*NIBBLES bits each: the operands of requester 0.
REQ-006 SHALL have port SUB_0, input, 1 bit: requester 0 operation select (1 = A-B, 0 = A+B).
REQ-007 SHALL have ports OPA_1, OPB_1 and SUB_1, inputs, with the same widths and meanings for requester 1.
REQ-008 SHALL have port GNT, output, 2 bits: one-cycle pulse on the granted requester, indicating its operands are captured.
REQ-009 SHALL have port BUSY, output, 1 bit: high while not IDLE.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port DONE_ID, output, 1 bit: index of the requester owning the current DONE.
REQ-012 SHALL have port RESULT, output, 4*NIBBLES bits: the sum or difference.
REQ-013 SHALL have ports COUT and OVF, outputs, 1 bit each: unsigned carry-out and signed overflow.
REQ-014 SHALL have ports ADD_A, ADD_B (outputs, 4 bits) and ADD_CIN (output, 1 bit): drive the external 4-bit ripple-adder slice.
REQ-015 SHALL have ports ADD_SUM (input, 4 bits) and ADD_COUT (input, 1 bit): the combinational response of the external slice.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 In IDLE with any REQ bit high, SHALL grant by round-robin and go to RUN: the pointer starts at 0; a sole requester wins regardless of the pointer.
REQ-018 On the grant edge, SHALL register A = OPA_g, B = OPB_g (bitwise inverted if SUB_g), carry = SUB_g, nibble index = 0, owner = g.
REQ-019 SHALL assert GNT[g] for exactly the first RUN cycle; operand changes after the grant edge SHALL NOT affect the result.
REQ-020 In RUN, SHALL drive ADD_A/ADD_B with the nibble of A/B at the current index and ADD_CIN with the carry register, combinationally from registers.
REQ-021 In RUN, each edge SHALL store ADD_SUM into that result nibble, load ADD_COUT into carry and increment the index; after nibble NIBBLES-1 it SHALL go to DONE.
REQ-022 When not in RUN, ADD_A, ADD_B and ADD_CIN SHALL be 0.
REQ-023 In DONE (one cycle), SHALL assert DONE, drive DONE_ID = owner, COUT = final carry and OVF = (A_msb == B_msb) && (RESULT_msb != A_msb), using post-inversion B.
REQ-024 On leaving DONE, SHALL return to IDLE and set the round-robin pointer to the other requester.
REQ-025 Latency SHALL be fixed: request sampled at edge k, DONE high after edge k+NIBBLES+1; minimum spacing between grants is NIBBLES+2 cycles.
REQ-026 RESULT, COUT, OVF and DONE_ID SHALL hold their last values until the next DONE.
REQ-027 REQ SHALL be ignored while BUSY; a REQ still high in IDLE is a new request.
REQ-028 In subtract mode, COUT = 1 SHALL mean no borrow.

Reset
REQ-029 RST_N low SHALL immediately force IDLE, the pointer to 0, and GNT, BUSY, DONE, DONE_ID, RESULT, COUT, OVF and all ADD_* outputs to 0, including mid-RUN; an aborted operation SHALL produce no DONE.
REQ-030 Operation SHALL resume at the first rising CLK edge after RST_N deasserts.

Verification
REQ-031 REQ[0], 0x1234 + 0x0FFF -> GNT[0] one cycle, DONE 5 cycles after the request edge, RESULT 0x2233, COUT 0, OVF 0, DONE_ID 0.
REQ-032 REQ[1], SUB_1 = 1, 0x0005 - 0x0007 -> RESULT 0xFFFE, COUT 0, OVF 0, DONE_ID 1.
REQ-033 0x7FFF + 0x0001 -> 0x8000, OVF 1, COUT 0; 0xFFFF + 0x0001 -> 0x0000, COUT 1, OVF 0.
REQ-034 Both REQ held high continuously -> grants alternate 0,1,0,1 starting with 0, DONE every 6 cycles, each result matching its owner's operands.
REQ-035 RST_N low after 2 RUN nibbles -> all outputs 0 at once, no DONE; after release with both REQ high -> requester 0 is granted first.
REQ-036 Operands changed the cycle after GNT -> RESULT matches the captured values.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Sequential adder/subtractor: arbitrates two requesters round-robin and computes
// A+B or A-B one nibble per cycle through an external 4-bit ripple-adder slice.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [1:0]             REQ,
    input  logic [4*NIBBLES-1:0]   OPA_0,
    input  logic [4*NIBBLES-1:0]   OPB_0,
    input  logic                   SUB_0,
    input  logic [4*NIBBLES-1:0]   OPA_1,
    input  logic [4*NIBBLES-1:0]   OPB_1,
    input  logic                   SUB_1,
    output logic [1:0]             GNT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   DONE_ID,
    output logic [4*NIBBLES-1:0]   RESULT,
    output logic                   COUT,
    output logic                   OVF,
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_SUM,
    input  logic                   ADD_COUT,
    output logic [1:0]             DBG_STATE
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic sel;
    logic sel_sub;

    // Handshake: REQ is a level; GNT pulses for one cycle on the requester whose
    // operands were captured, DONE pulses for one cycle when RESULT/COUT/OVF/DONE_ID
    // are valid. REQ is not looked at while BUSY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        gnt_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        sel       = (REQ == 2'b11) ? ptr_q : REQ[1];
        sel_sub   = sel ? SUB_1 : SUB_0;

        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    state_d = S_RUN;
                    owner_d = sel;
                    a_d     = sel ? OPA_1 : OPA_0;
                    b_d     = (sel ? OPB_1 : OPB_0) ^ {W{sel_sub}};
                    carry_d = sel_sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                end
            end
            S_RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = ADD_SUM;
                carry_d = ADD_COUT;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Results are published on the edge leaving DONE, so the DONE pulse
                // lands NIBBLES+1 edges after the request was sampled.
                state_d   = S_IDLE;
                done_d    = 1'b1;
                done_id_d = owner_q;
                result_d  = acc_q;
                cout_d    = carry_q;
                ovf_d     = (a_q[W-1] == b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
                ptr_d     = ~owner_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign GNT       = gnt_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign DONE_ID   = done_id_q;
    assign RESULT    = result_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign DBG_STATE = state_q;

    assign ADD_A   = (state_q == S_RUN) ? a_q[{idx_q, 2'b00} +: 4] : 4'b0000;
    assign ADD_B   = (state_q == S_RUN) ? b_q[{idx_q, 2'b00} +: 4] : 4'b0000;
    assign ADD_CIN = (state_q == S_RUN) ? carry_q : 1'b0;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: vector table, random ops, round-robin and mid-run reset,
// with a scoreboard checking every DONE against the expected queue.
module tb_adder_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] opa_0, opb_0, opa_1, opb_1;
    logic         sub_0, sub_1;
    logic [1:0]   gnt;
    logic         busy, done, done_id, cout, ovf;
    logic [W-1:0] result;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W+2:0] exp_q[$];
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } vec_t;
    vec_t vecs[8];

    adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req),
        .OPA_0(opa_0), .OPB_0(opb_0), .SUB_0(sub_0),
        .OPA_1(opa_1), .OPB_1(opb_1), .SUB_1(sub_1),
        .GNT(gnt), .BUSY(busy), .DONE(done), .DONE_ID(done_id),
        .RESULT(result), .COUT(cout), .OVF(ovf),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout), .DBG_STATE(dbg_state)
    );

    // External ripple-adder slice.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        return {id, s[W], (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]), s[W-1:0]};
    endfunction

    // Scoreboard: every DONE must match the oldest expected {id, cout, ovf, result}.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {done_id, cout, ovf, result}, '0);
            end else begin
                chk("sb_result", {done_id, cout, ovf, result}, exp_q.pop_front());
            end
        end
    end

    task automatic run_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic [W+2:0] exp);
        int   cyc;
        logic seen;
        if (id) begin
            opa_1 = a; opb_1 = b; sub_1 = sub; req = 2'b10;
        end else begin
            opa_0 = a; opb_0 = b; sub_0 = sub; req = 2'b01;
        end
        exp_q.push_back(exp);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("gnt", gnt, id ? 2'b10 : 2'b01);
                chk("add_a_nib0", add_a, a[3:0]);
                chk("add_cin_nib0", add_cin, sub);
                req = 2'b00;
                // Operands change right after capture; result must not follow.
                if (id) begin
                    opa_1 = W'($urandom); opb_1 = W'($urandom); sub_1 = ~sub;
                end else begin
                    opa_0 = W'($urandom); opb_0 = W'($urandom); sub_0 = ~sub;
                end
            end
            if (cyc == 2) chk("gnt_pulse", gnt, 2'b00);
            if (cyc == 3) chk("result_hold", result, last_res);
            if (done) seen = 1'b1;
        end
        chk("done_latency", cyc, NIBBLES + 2);
        chk("add_idle", {add_a, add_b, add_cin}, '0);
        last_res = exp[W-1:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs, rid;
        int           c, cyc_abs, last_done;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        req   = 2'b00;
        opa_0 = '0; opb_0 = '0; sub_0 = 1'b0;
        opa_1 = '0; opb_1 = '0; sub_1 = 1'b0;
        #1;
        chk("reset_outputs", {gnt, busy, done, done_id, result, cout, ovf, add_a, add_b, add_cin, dbg_state}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, gnt}, '0);

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
                    {vecs[i].id, vecs[i].c, vecs[i].o, vecs[i].res});
        end

        for (int i = 0; i < 6; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rs  = 1'($urandom_range(0, 1));
            rid = 1'($urandom_range(0, 1));
            run_one(rid, ra, rb, rs, model(rid, ra, rb, rs));
        end

        // Leave the pointer at 1, then abort a requester-1 op mid-RUN.
        ra = 16'hA5A5;
        rb = 16'h1111;
        run_one(1'b0, ra, rb, 1'b0, model(1'b0, ra, rb, 1'b0));
        opa_1 = 16'h0F0F; opb_1 = 16'h0101; sub_1 = 1'b0;
        req = 2'b10;
        @(negedge clk);
        chk("abort_gnt", gnt, 2'b10);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("abort_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {gnt, busy, done, done_id, result, cout, ovf, add_a, add_b, add_cin, dbg_state}, '0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done, 1'b0);
        last_res = '0;

        // Both requesters held: grants alternate starting with 0.
        opa_0 = 16'h1234; opb_0 = 16'h0FFF; sub_0 = 1'b0;
        opa_1 = 16'h0005; opb_1 = 16'h0007; sub_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 1) ? {1'b1, 1'b0, 1'b0, 16'hFFFE} : {1'b0, 1'b0, 1'b0, 16'h2233});
        end
        rst_n = 1'b1;
        req = 2'b11;
        cyc_abs = 0;
        last_done = 0;
        for (int op = 0; op < 4; op++) begin
            c = 0;
            do begin @(negedge clk); c++; cyc_abs++; end while (gnt == 2'b00 && c < 20);
            chk("rr_gnt", gnt, (op % 2 == 1) ? 2'b10 : 2'b01);
            c = 0;
            do begin @(negedge clk); c++; cyc_abs++; end while (!done && c < 20);
            chk("rr_latency", c, NIBBLES + 1);
            if (op > 0) chk("rr_spacing", cyc_abs - last_done, NIBBLES + 2);
            last_done = cyc_abs;
            if (op == 3) req = 2'b00;
        end

        repeat (NIBBLES + 4) @(negedge clk);
        chk("no_extra_grant", {busy, gnt}, '0);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
